// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the runtime-programmable LUT neuron bank.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } cfg_state_e;

  localparam int IN_BITS_DEFAULT = 6;
  localparam int WORD_W_DEFAULT  = 32;
  localparam int WORDS_PER_TABLE = (2 ** IN_BITS_DEFAULT) / WORD_W_DEFAULT;

  function automatic int words_per_table(input int in_bits, input int word_w);
    return (2 ** in_bits) / word_w;
  endfunction

endpackage

// File: rtl/lut_table_bank.sv
// Word-organised storage for all neuron truth tables: one config word write port,
// one registered single-bit read port. Contents are deliberately not reset.
module lut_table_bank
  import lut_cfg_pkg::*;
#(
  parameter int NUM_NEURONS = 64,
  parameter int IN_BITS     = IN_BITS_DEFAULT,
  parameter int WORD_W      = WORD_W_DEFAULT,
  localparam int WPT        = words_per_table(IN_BITS, WORD_W),
  localparam int DEPTH      = NUM_NEURONS * WPT,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW         = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [BW-1:0]     rd_bit_i,
  output logic              rd_bit_o
);

  (* ram_style = "distributed" *) logic [WORD_W-1:0] mem_q [DEPTH];
  logic rd_bit_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_bit_q <= mem_q[rd_addr_i][rd_bit_i];
    end
  end

  assign rd_bit_o = rd_bit_q;

endmodule

// File: rtl/lut_table_loader.sv
// Streams a table bank in from 32-bit config words, verifies the XOR checksum,
// commits the bank and serves registered single-neuron lookups.
module lut_table_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_NEURONS = 64,
  parameter int IN_BITS     = IN_BITS_DEFAULT,
  parameter int WORD_W      = WORD_W_DEFAULT,
  // One extra code point so an out-of-range neuron index is expressible.
  localparam int NW         = $clog2(NUM_NEURONS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [WORD_W-1:0]  cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               bank_ok,
  input  logic               lk_valid,
  input  logic [NW-1:0]      lk_neuron,
  input  logic [IN_BITS-1:0] M0,
  output logic               M1_valid,
  output logic               M1
);

  localparam int WPT   = words_per_table(IN_BITS, WORD_W);
  localparam int TOTAL = NUM_NEURONS * WPT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW    = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_WORD = CW'(TOTAL - 1);

  cfg_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              bank_ok_q, bank_ok_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              ready_c;
  logic              wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      bank_ok_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      bank_ok_q <= bank_ok_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    bank_ok_d = bank_ok_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ready_c   = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          csum_d    = '0;
          bank_ok_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        ready_c = 1'b1;
        if (cfg_valid) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ cfg_data;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        ready_c = 1'b1;
        if (cfg_valid) begin
          state_d = IDLE;
          if (cfg_data == csum_q) begin
            bank_ok_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = ready_c;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign bank_ok   = bank_ok_q;

  // Lookups are only accepted once committed, so reads never see a half-written bank.
  logic          lk_en, in_range;
  logic [AW-1:0] rd_addr;
  logic          m1_valid_q, hit_q;
  logic          rd_bit;

  assign lk_en    = lk_valid & bank_ok_q;
  assign in_range = int'(lk_neuron) < NUM_NEURONS;

  always_comb begin
    rd_addr = '0;
    if (in_range) begin
      rd_addr = AW'(int'(lk_neuron) * WPT + int'(M0) / WORD_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1_valid_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      m1_valid_q <= lk_en;
      hit_q      <= lk_en & in_range;
    end
  end

  lut_table_bank #(
    .NUM_NEURONS(NUM_NEURONS),
    .IN_BITS    (IN_BITS),
    .WORD_W     (WORD_W)
  ) u_bank (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(AW'(cnt_q)),
    .wr_data_i(cfg_data),
    .rd_en_i  (lk_en & in_range),
    .rd_addr_i(rd_addr),
    .rd_bit_i (M0[BW-1:0]),
    .rd_bit_o (rd_bit)
  );

  assign M1_valid = m1_valid_q;
  assign M1       = hit_q & rd_bit;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader with a transaction-level reference model.
module tb_lut_table_loader;

  localparam int NN    = 64;
  localparam int WPT   = 2;
  localparam int TOTAL = NN * WPT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, cfg_done, cfg_err, bank_ok;
  logic        lk_valid = 1'b0;
  logic [6:0]  lk_neuron = '0;
  logic [5:0]  M0 = '0;
  logic        M1_valid, M1;

  always #5 clk = ~clk;

  lut_table_loader dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .bank_ok  (bank_ok),
    .lk_valid (lk_valid),
    .lk_neuron(lk_neuron),
    .M0       (M0),
    .M1_valid (M1_valid),
    .M1       (M1)
  );

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is simply the list of words accepted since the start;
  // once TOTAL+1 words are in, the last one is compared with the XOR of the rest.
  bit          m_loading = 1'b0, m_ok = 1'b0, m_err = 1'b0, m_done = 1'b0;
  bit          e_m1v = 1'b0, e_m1 = 1'b0;
  bit [31:0]   m_words[$];
  bit [31:0]   m_tbl[TOTAL];
  bit [31:0]   m_x;

  function automatic bit tbl_bit(input int n, input int m);
    bit [31:0] w;
    w = m_tbl[n * WPT + m / 32];
    return w[m % 32];
  endfunction

  always @(posedge clk) begin
    e_m1v  = !rst && lk_valid && m_ok;
    e_m1   = e_m1v && (int'(lk_neuron) < NN) && tbl_bit(int'(lk_neuron), int'(M0));
    m_done = 1'b0;
    if (rst) begin
      m_loading = 1'b0;
      m_ok      = 1'b0;
      m_err     = 1'b0;
    end else if (m_loading) begin
      if (cfg_valid) begin
        m_words.push_back(cfg_data);
        if (m_words.size() == TOTAL + 1) begin
          m_x = '0;
          for (int i = 0; i < TOTAL; i++) m_x ^= m_words[i];
          if (m_x == m_words[TOTAL]) begin
            m_ok   = 1'b1;
            m_done = 1'b1;
            for (int i = 0; i < TOTAL; i++) m_tbl[i] = m_words[i];
          end else begin
            m_err = 1'b1;
          end
          m_loading = 1'b0;
        end
      end
    end else if (cfg_start) begin
      m_loading = 1'b1;
      m_words.delete();
      m_ok  = 1'b0;
      m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", 32'(cfg_ready), 32'(m_loading));
      check("cfg_done",  32'(cfg_done),  32'(m_done));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
      check("bank_ok",   32'(bank_ok),   32'(m_ok));
      check("M1_valid",  32'(M1_valid),  32'(e_m1v));
      check("M1",        32'(M1),        32'(e_m1));
      if (cfg_done === 1'b1) done_seen++;
    end
  end

  logic [31:0] stim[TOTAL];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    int n;
    cfg_data  = d;
    cfg_valid = 1'b1;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ready_timeout", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  function automatic logic [31:0] stim_xor();
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < TOTAL; i++) x ^= stim[i];
    return x;
  endfunction

  task automatic run_load(input logic [31:0] csum, input bit gaps, input bit start_mid);
    start_load();
    for (int i = 0; i < TOTAL; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      if (start_mid && i == 80) begin
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
      end
      if (start_mid && i == 50) cfg_start = 1'b1;
      send_word(stim[i]);
      cfg_start = 1'b0;
    end
    if (start_mid) cfg_start = 1'b1;
    send_word(csum);
    cfg_start = 1'b0;
    tick();
  endtask

  task automatic lookup(input int n, input int m);
    lk_valid  = 1'b1;
    lk_neuron = 7'(n);
    M0        = 6'(m);
    tick();
    lk_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 1: idle after reset, lookups gated
    check("t1_ready_idle", 32'(cfg_ready), 32'd0);
    lookup(0, 2);
    check("t1_m1_valid", 32'(M1_valid), 32'd0);
    check("t1_m1", 32'(M1), 32'd0);

    // 2: uniform 0xAAAAAAAA load, lookup held on across the commit cycle
    for (int i = 0; i < TOTAL; i++) stim[i] = 32'hAAAA_AAAA;
    lk_valid = 1'b1; lk_neuron = 7'd5; M0 = 6'h01;
    run_load(32'h0000_0000, 1'b0, 1'b0);
    lk_valid = 1'b0;
    check("t2_bank_ok", 32'(bank_ok), 32'd1);
    lookup(17, 1);
    check("t2_m1v_n17", 32'(M1_valid), 32'd1);
    check("t2_m1_n17_m1", 32'(M1), 32'd1);
    lookup(17, 0);
    check("t2_m1_n17_m0", 32'(M1), 32'd0);
    lookup(63, 33);
    check("t2_m1_n63_m33", 32'(M1), 32'd1);
    check("t2_done_once", 32'(done_seen), 32'd1);

    // 3: bad checksum
    run_load(32'h0000_0001, 1'b0, 1'b0);
    check("t3_err", 32'(cfg_err), 32'd1);
    check("t3_bank_ok", 32'(bank_ok), 32'd0);
    lookup(3, 1);
    check("t3_m1_valid", 32'(M1_valid), 32'd0);
    check("t3_no_done", 32'(done_seen), 32'd1);

    // 4: random data, valid gaps, cfg_start pulses mid-load and on the checksum beat
    for (int i = 0; i < TOTAL; i++) stim[i] = $urandom();
    run_load(stim_xor(), 1'b1, 1'b1);
    check("t4_bank_ok", 32'(bank_ok), 32'd1);
    check("t4_done", 32'(done_seen), 32'd2);
    lk_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      lk_neuron = 7'($urandom_range(0, NN - 1));
      M0 = 6'($urandom_range(0, 63));
      tick();
    end
    lk_valid = 1'b0;

    // 5: reset aborts a partial load, then a fresh full load is swept completely
    for (int i = 0; i < TOTAL; i++) stim[i] = $urandom();
    start_load();
    for (int i = 0; i < 37; i++) send_word(stim[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_abort_bank_ok", 32'(bank_ok), 32'd0);
    check("t5_abort_ready", 32'(cfg_ready), 32'd0);
    stim[0] = 32'h0000_0001;
    stim[1] = 32'h8000_0000;
    run_load(stim_xor(), 1'b0, 1'b0);
    lookup(0, 0);
    check("t5_n0_m0", 32'(M1), 32'd1);
    lookup(0, 63);
    check("t5_n0_m63", 32'(M1), 32'd1);
    lookup(0, 62);
    check("t5_n0_m62", 32'(M1), 32'd0);
    lk_valid = 1'b1;
    for (int n = 0; n < NN; n++) begin
      for (int m = 0; m < 64; m++) begin
        lk_neuron = 7'(n);
        M0 = 6'(m);
        tick();
      end
    end

    // 6: streaming lookups with out-of-range neuron interleaved
    for (int i = 0; i < 40; i++) begin
      lk_neuron = (i % 3 == 2) ? 7'd64 : 7'(i);
      M0 = 6'(i * 7);
      tick();
      check("t6_stream_valid", 32'(M1_valid), 32'd1);
      if (i % 3 == 2) check("t6_oor_m1", 32'(M1), 32'd0);
    end
    lk_valid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
